// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - stall/flush controller for the 5-stage rv32i pipeline
// Freezes the whole pipe on cache misses, bubbles on load-use, flushes on EX redirects.
module hazard_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic             IFID_uses_rs1,
  input  logic             IFID_uses_rs2,
  input  logic [4:0]       IDEX_rd,
  input  logic             IDEX_mem_read,
  input  logic             EX_redirect,
  input  logic             icache_req,
  input  logic             icache_resp,
  input  logic             dcache_req,
  input  logic             dcache_resp,
  input  logic             perf_clear,
  output logic             pc_load,
  output logic             IFID_load,
  output logic             IDEX_load,
  output logic             EXMEM_load,
  output logic             MEMWB_load,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic [CNT_W-1:0] perf_loaduse_cnt,
  output logic [CNT_W-1:0] perf_memstall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  typedef enum logic {RUN, WAIT} state_t;

  state_t state, state_next;
  logic   i_done, d_done, i_done_next, d_done_next;
  logic   loaduse, i_ok, d_ok, go;
  logic   inc_loaduse, inc_flush, inc_memstall;

  assign loaduse = IDEX_mem_read && (IDEX_rd != 5'd0) &&
                   ((IFID_uses_rs1 && (IFID_rs1 == IDEX_rd)) ||
                    (IFID_uses_rs2 && (IFID_rs2 == IDEX_rd)));
  assign i_ok = ~icache_req | icache_resp | i_done;
  assign d_ok = ~dcache_req | dcache_resp | d_done;
  assign go   = i_ok & d_ok;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= RUN;
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      state  <= state_next;
      i_done <= i_done_next;
      d_done <= d_done_next;
    end
  end

  always_comb begin
    state_next  = state;
    i_done_next = i_done;
    d_done_next = d_done;
    case (state)
      RUN: begin
        if (!go) begin
          state_next  = WAIT;
          i_done_next = ~icache_req | icache_resp;
          d_done_next = ~dcache_req | dcache_resp;
        end
      end
      WAIT: begin
        if (go) begin
          state_next  = RUN;
          i_done_next = 1'b0;
          d_done_next = 1'b0;
        end else begin
          i_done_next = i_done | icache_resp;
          d_done_next = d_done | dcache_resp;
        end
      end
      default: begin
        state_next  = RUN;
        i_done_next = 1'b0;
        d_done_next = 1'b0;
      end
    endcase
  end

  // Release cycles share the advance path; a held redirect flushes only here.
  always_comb begin
    pc_load     = 1'b0;
    IFID_load   = 1'b0;
    IDEX_load   = 1'b0;
    EXMEM_load  = 1'b0;
    MEMWB_load  = 1'b0;
    IFID_flush  = 1'b0;
    IDEX_bubble = 1'b0;
    if (rst && go) begin
      IDEX_load  = 1'b1;
      EXMEM_load = 1'b1;
      MEMWB_load = 1'b1;
      if (EX_redirect) begin
        pc_load     = 1'b1;
        IFID_load   = 1'b1;
        IFID_flush  = 1'b1;
        IDEX_bubble = 1'b1;
      end else if (loaduse) begin
        IDEX_bubble = 1'b1;
      end else begin
        pc_load   = 1'b1;
        IFID_load = 1'b1;
      end
    end
  end

  assign inc_loaduse  = go & ~EX_redirect & loaduse;
  assign inc_flush    = go & EX_redirect;
  assign inc_memstall = ~go;

  always_ff @(posedge clk) begin
    if (!rst || perf_clear) begin
      perf_loaduse_cnt  <= '0;
      perf_memstall_cnt <= '0;
      perf_flush_cnt    <= '0;
    end else begin
      if (inc_loaduse && (perf_loaduse_cnt != '1))
        perf_loaduse_cnt <= perf_loaduse_cnt + CNT_W'(1);
      if (inc_memstall && (perf_memstall_cnt != '1))
        perf_memstall_cnt <= perf_memstall_cnt + CNT_W'(1);
      if (inc_flush && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - scoreboard bench for hazard_control_unit
// Driver pushes model expectations per cycle; monitor pops and compares on the falling edge.
module tb_hazard_control_unit;

  localparam int CNT_W = 4;
  localparam int MAXC  = 15;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       redir;
    logic       ireq;
    logic       iresp;
    logic       dreq;
    logic       dresp;
    logic       clr;
  } stim_t;

  typedef struct {
    logic [4:0] loads;
    logic       flush;
    logic       bubble;
    int         lu;
    int         ms;
    int         fl;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  stim_t cur = '0;
  logic pc_load, IFID_load, IDEX_load, EXMEM_load, MEMWB_load, IFID_flush, IDEX_bubble;
  logic [CNT_W-1:0] perf_loaduse_cnt, perf_memstall_cnt, perf_flush_cnt;

  hazard_control_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(cur.rst),
    .IFID_rs1(cur.rs1), .IFID_rs2(cur.rs2),
    .IFID_uses_rs1(cur.u1), .IFID_uses_rs2(cur.u2),
    .IDEX_rd(cur.rd), .IDEX_mem_read(cur.mr), .EX_redirect(cur.redir),
    .icache_req(cur.ireq), .icache_resp(cur.iresp),
    .dcache_req(cur.dreq), .dcache_resp(cur.dresp),
    .perf_clear(cur.clr),
    .pc_load(pc_load), .IFID_load(IFID_load), .IDEX_load(IDEX_load),
    .EXMEM_load(EXMEM_load), .MEMWB_load(MEMWB_load),
    .IFID_flush(IFID_flush), .IDEX_bubble(IDEX_bubble),
    .perf_loaduse_cnt(perf_loaduse_cnt), .perf_memstall_cnt(perf_memstall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
  );

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: "is the pipe waiting" plus "which response has already arrived".
  bit m_wait = 0, m_i = 0, m_d = 0;
  int m_lu = 0, m_ms = 0, m_fl = 0;

  function automatic int sat(input int v);
    return (v + 1 > MAXC) ? MAXC : v + 1;
  endfunction

  function automatic stim_t idle();
    stim_t s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s, output bit adv);
    exp_t e;
    bit   luse, iok, dok;
    @(posedge clk);
    #2;
    cur = s;
    e.lu = m_lu; e.ms = m_ms; e.fl = m_fl;
    e.loads = 5'b0; e.flush = 1'b0; e.bubble = 1'b0;
    adv = 1'b0;
    if (!s.rst) begin
      m_wait = 0; m_i = 0; m_d = 0; m_lu = 0; m_ms = 0; m_fl = 0;
    end else begin
      luse = s.mr && s.rd != 0 && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      iok  = !s.ireq || s.iresp || m_i;
      dok  = !s.dreq || s.dresp || m_d;
      if (!(iok && dok)) begin
        if (!m_wait) begin
          m_i = !s.ireq || s.iresp;
          m_d = !s.dreq || s.dresp;
        end else begin
          m_i = m_i || s.iresp;
          m_d = m_d || s.dresp;
        end
        m_wait = 1;
        m_ms = sat(m_ms);
      end else begin
        adv = 1'b1;
        m_wait = 0; m_i = 0; m_d = 0;
        if (s.redir) begin
          e.loads = 5'b11111; e.flush = 1'b1; e.bubble = 1'b1;
          m_fl = sat(m_fl);
        end else if (luse) begin
          e.loads = 5'b00111; e.bubble = 1'b1;
          m_lu = sat(m_lu);
        end else begin
          e.loads = 5'b11111;
        end
      end
      if (s.clr) begin
        m_lu = 0; m_ms = 0; m_fl = 0;
      end
    end
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ctrl{pc,ifid,idex,exmem,memwb,flush,bubble}",
            int'({pc_load, IFID_load, IDEX_load, EXMEM_load, MEMWB_load, IFID_flush, IDEX_bubble}),
            int'({e.loads, e.flush, e.bubble}));
        chk("loaduse_cnt", int'(perf_loaduse_cnt), e.lu);
        chk("memstall_cnt", int'(perf_memstall_cnt), e.ms);
        chk("flush_cnt", int'(perf_flush_cnt), e.fl);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    bit    adv;
    bit    i_act = 0, i_given = 0, d_act = 0, d_given = 0, r_hold = 0;
    int    i_lat = 0, d_lat = 0;

    s = idle(); s.rst = 1'b0;
    apply(s, adv); apply(s, adv);

    // Load-use on rs1, then same with rd=0
    s = idle(); s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
    apply(s, adv);
    s.rd = 0; s.rs1 = 0;
    apply(s, adv);
    chk("directed loaduse count", int'(perf_loaduse_cnt), 1);
    s = idle(); s.clr = 1; apply(s, adv);

    // Icache miss, response in cycle 3
    for (int c = 0; c < 4; c++) begin
      s = idle(); s.ireq = 1; s.iresp = (c == 3);
      apply(s, adv);
    end
    s = idle(); apply(s, adv);
    chk("directed icache memstall", int'(perf_memstall_cnt), 3);
    s = idle(); s.clr = 1; apply(s, adv);

    // Split responses: icache at 1, dcache at 4
    for (int c = 0; c < 5; c++) begin
      s = idle(); s.ireq = 1; s.dreq = 1; s.iresp = (c == 1); s.dresp = (c == 4);
      apply(s, adv);
    end
    s = idle(); apply(s, adv);
    chk("directed split memstall", int'(perf_memstall_cnt), 4);
    s = idle(); s.clr = 1; apply(s, adv);

    // Redirect and load-use together
    s = idle(); s.redir = 1; s.mr = 1; s.rd = 7; s.rs2 = 7; s.u2 = 1;
    apply(s, adv);
    s = idle(); apply(s, adv);
    chk("directed redirect flush", int'(perf_flush_cnt), 1);
    chk("directed redirect loaduse", int'(perf_loaduse_cnt), 0);
    s = idle(); s.clr = 1; apply(s, adv);

    // Redirect held through a dcache miss
    for (int c = 0; c < 3; c++) begin
      s = idle(); s.redir = 1; s.dreq = 1; s.dresp = (c == 2);
      apply(s, adv);
    end
    s = idle(); apply(s, adv);
    chk("directed frozen redirect flush", int'(perf_flush_cnt), 1);

    // Saturation, then clear colliding with an increment
    s = idle(); s.mr = 1; s.rd = 3; s.rs1 = 3; s.u1 = 1;
    for (int c = 0; c < 20; c++) apply(s, adv);
    s = idle(); apply(s, adv);
    chk("directed loaduse saturate", int'(perf_loaduse_cnt), MAXC);
    s = idle(); s.mr = 1; s.rd = 3; s.rs1 = 3; s.u1 = 1; s.clr = 1;
    apply(s, adv);
    s = idle(); apply(s, adv);
    chk("directed clear beats increment", int'(perf_loaduse_cnt), 0);

    // Reset while waiting drops the pending response
    s = idle(); s.dreq = 1;
    apply(s, adv); apply(s, adv);
    s.rst = 0; s.dresp = 1;
    apply(s, adv);
    s = idle(); s.dreq = 1;
    apply(s, adv);
    chk("directed reset clears memstall", int'(perf_memstall_cnt), 0);
    apply(s, adv);
    s.dresp = 1;
    apply(s, adv);

    // Randomized traffic with cache latencies held until the release cycle
    for (int c = 0; c < 3000; c++) begin
      s = idle();
      if (!i_act && $urandom_range(2) == 0) begin i_act = 1; i_given = 0; i_lat = $urandom_range(3); end
      if (!d_act && $urandom_range(3) == 0) begin d_act = 1; d_given = 0; d_lat = $urandom_range(4); end
      s.ireq  = i_act;
      s.iresp = i_act && !i_given && i_lat == 0;
      s.dreq  = d_act;
      s.dresp = d_act && !d_given && d_lat == 0;
      s.redir = r_hold || ($urandom_range(7) == 0);
      s.rs1 = 5'($urandom_range(3)); s.rs2 = 5'($urandom_range(3)); s.rd = 5'($urandom_range(3));
      s.u1 = 1'($urandom); s.u2 = 1'($urandom); s.mr = 1'($urandom);
      s.clr = ($urandom_range(29) == 0);
      s.rst = !($urandom_range(199) == 0);
      apply(s, adv);
      if (i_act && !i_given) begin if (i_lat == 0) i_given = 1; else i_lat--; end
      if (d_act && !d_given) begin if (d_lat == 0) d_given = 1; else d_lat--; end
      if (adv || !s.rst) begin
        i_act = 0; d_act = 0; r_hold = 0;
      end else begin
        r_hold = s.redir;
      end
    end

    repeat (3) @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
